// File: rtl/tcore_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tcore_mem_arbiter                                                          |
// | Round-robin sharing of the lower memory port between I-cache and D-cache.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package tcore_param;
  localparam int BLK_SIZE = 128;

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        uncached;
  } ilowX_req_t;

  typedef struct packed {
    logic                ready;
    logic                valid;
    logic [BLK_SIZE-1:0] blk;
  } ilowX_res_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [31:0]         addr;
    logic                rw;
    logic [1:0]          rw_type;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } dlowX_req_t;

  typedef struct packed {
    logic                ready;
    logic                valid;
    logic [BLK_SIZE-1:0] data;
  } dlowX_res_t;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           addr;
    logic [BLK_SIZE/8-1:0] rw;
  } mem_req_t;
endpackage

module tcore_mem_arbiter #(
  parameter int BLK_SIZE = tcore_param::BLK_SIZE
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  tcore_param::ilowX_req_t ilowx_req_i,
  output tcore_param::ilowX_res_t ilowx_res_o,
  input  tcore_param::dlowX_req_t dlowx_req_i,
  output tcore_param::dlowX_res_t dlowx_res_o,
  output tcore_param::mem_req_t   mem_req_o,
  output logic [BLK_SIZE-1:0]    mem_wdata_o,
  input  logic                   mem_ready_i,
  input  logic                   mem_rvalid_i,
  input  logic [BLK_SIZE-1:0]    mem_rdata_i
);

  localparam int SW = BLK_SIZE / 8;
  localparam logic [SW-1:0] c_strb_byte = SW'(16'h0001);
  localparam logic [SW-1:0] c_strb_half = SW'(16'h0003);
  localparam logic [SW-1:0] c_strb_word = SW'(16'h000F);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_rdata_cap;
  logic                r_last_d;
  logic                r_owner;
  logic                r_accept;
  logic [31:0]         r_addr;
  logic [SW-1:0]       r_strb;
  logic [BLK_SIZE-1:0] r_wdata;
  logic [BLK_SIZE-1:0] r_rdata;

  logic                w_any;
  logic                w_grant_d;
  logic                w_owner_rdy;
  logic                w_resp_i;
  logic                w_resp_d;
  logic [3:0]          w_off;
  logic [SW-1:0]       w_strb;
  logic                w_unused;

  assign w_any       = ilowx_req_i.valid | dlowx_req_i.valid;
  // Instruction wins a tie only when data was granted last.
  assign w_grant_d   = dlowx_req_i.valid & (~ilowx_req_i.valid | ~r_last_d);
  assign w_owner_rdy = r_owner ? dlowx_req_i.ready : ilowx_req_i.ready;
  assign w_off       = dlowx_req_i.addr[3:0];
  assign w_unused    = ^{ilowx_req_i.addr[3:0], ilowx_req_i.uncached, dlowx_req_i.uncached};

  always_comb begin
    w_strb = '0;
    if (dlowx_req_i.rw) begin
      unique case (dlowx_req_i.rw_type)
        2'b00:   w_strb = '1;
        2'b01:   w_strb = c_strb_byte << w_off;
        2'b10:   w_strb = c_strb_half << {w_off[3:1], 1'b0};
        default: w_strb = c_strb_word << {w_off[3:2], 2'b00};
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_cap = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready_i) begin
          if (mem_rvalid_i) begin
            w_state_nxt = RESP;
            w_rdata_cap = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          w_state_nxt = RESP;
          w_rdata_cap = 1'b1;
        end
      end
      RESP: begin
        if (w_owner_rdy) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_last_d <= 1'b1;
      r_owner  <= 1'b0;
      r_accept <= 1'b0;
      r_addr   <= '0;
      r_strb   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_accept <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_accept <= 1'b1;
        r_owner  <= w_grant_d;
        r_last_d <= w_grant_d;
        r_addr   <= w_grant_d ? {dlowx_req_i.addr[31:4], 4'b0000}
                              : {ilowx_req_i.addr[31:4], 4'b0000};
        r_strb   <= w_grant_d ? w_strb : '0;
        r_wdata  <= w_grant_d ? dlowx_req_i.data : '0;
      end
      if (w_rdata_cap) begin
        r_rdata <= mem_rdata_i;
      end
    end
  end

  assign w_resp_i = (r_state == RESP) & ~r_owner;
  assign w_resp_d = (r_state == RESP) &  r_owner;

  always_comb begin
    ilowx_res_o       = '0;
    ilowx_res_o.ready = r_accept & ~r_owner;
    ilowx_res_o.valid = w_resp_i;
    ilowx_res_o.blk   = w_resp_i ? r_rdata : '0;

    dlowx_res_o       = '0;
    dlowx_res_o.ready = r_accept & r_owner;
    dlowx_res_o.valid = w_resp_d;
    dlowx_res_o.data  = w_resp_d ? r_rdata : '0;

    mem_req_o         = '0;
    mem_req_o.valid   = (r_state == ISSUE);
    mem_req_o.addr    = r_addr;
    mem_req_o.rw      = r_strb;
  end

  assign mem_wdata_o = r_wdata;

endmodule
`default_nettype wire
